// File: rtl/ysyx_23060025_rd_arbiter.sv
// ysyx_23060025_rd_arbiter
// ------------------------
// Shares the single AXI4 read port to DRAM between two requesters:
//   - the icache refill path (ic_*), which issues multi-beat bursts, and
//   - LSU loads (ls_*), which always issue a single-beat read (arlen = 0).
// The arbiter sits between ysyx_23060025_icache / LSU and the SoC AXI master.
// It issues one AR at a time, routes the returning R beats to the owner of the
// outstanding read, keeps the icache from starving behind back-to-back loads,
// and flags bursts whose rlast does not line up with the requested length.
//
// Flow: StIdle --grant--> StAr --m_arready--> StR --last beat--> StIdle
//
// Ports
//   clock, reset         clock; synchronous active-high reset
//   ic_psel              icache refill request, held through the burst
//   ic_paddr/arlen/arsize icache line address, burst length-1, beat size
//   ic_rvalid/rlast/rdata beat to icache (valid only for icache-owned beats)
//   ls_req               LSU load request, held until ls_rvalid
//   ls_addr/arsize       load address and size
//   ls_rvalid/rdata/rresp load return, single-cycle pulse
//   m_ar*                AXI AR channel towards the SoC master
//   m_r*                 AXI R channel from the SoC master
//   len_err              sticky: rlast seen with beat count != latched arlen+1

module ysyx_23060025_rd_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clock,
    input  logic                  reset,

    // icache refill port
    input  logic                  ic_psel,
    input  logic [ADDR_WIDTH-1:0] ic_paddr,
    input  logic [7:0]            ic_arlen,
    input  logic [2:0]            ic_arsize,
    output logic                  ic_rvalid,
    output logic                  ic_rlast,
    output logic [DATA_WIDTH-1:0] ic_rdata,

    // LSU load port
    input  logic                  ls_req,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [2:0]            ls_arsize,
    output logic                  ls_rvalid,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic [1:0]            ls_rresp,

    // AXI read address channel
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,

    // AXI read data channel
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,

    // Status
    output logic                  len_err
);

    // Counter wide enough to hold STARVE_MAX itself (saturating value).
    localparam int unsigned STARVE_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StAr,
        StR
    } state_e;

    typedef enum logic [1:0] {
        OwnNone,
        OwnIc,
        OwnLs
    } owner_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                state_q,      state_d;
    owner_e                owner_q,      owner_d;
    logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic [7:0]            beat_cnt_q,   beat_cnt_d;
    logic                  len_err_q,    len_err_d;
    logic                  ic_mask_q,    ic_mask_d;
    logic                  ls_mask_q,    ls_mask_d;
    logic [ADDR_WIDTH-1:0] araddr_q,     araddr_d;
    logic [7:0]            arlen_q,      arlen_d;
    logic [2:0]            arsize_q,     arsize_d;

    // ------------------------------------------------------------------
    // Arbitration and beat qualification
    // ------------------------------------------------------------------
    logic ic_cand;
    logic ls_cand;
    logic starve_hit;
    logic grant_ls;
    logic grant_ic;
    logic r_beat;
    logic ic_beat;
    logic ls_beat;
    logic r_done;

    // A requester that just completed still shows its request for one more
    // cycle; the mask keeps that stale request from earning a second grant.
    assign ic_cand    = ic_psel & ~ic_mask_q;
    assign ls_cand    = ls_req  & ~ls_mask_q;
    assign starve_hit = (starve_cnt_q == STARVE_LIMIT);

    // LSU wins ties, except once the icache has been passed over too often.
    assign grant_ls = (state_q == StIdle) & ls_cand & ~(ic_cand & starve_hit);
    assign grant_ic = (state_q == StIdle) & ic_cand & ~grant_ls;

    // m_rready is high in StR, so every m_rvalid there is an accepted beat.
    assign r_beat  = (state_q == StR) & m_rvalid;
    assign ic_beat = r_beat & (owner_q == OwnIc);
    assign ls_beat = r_beat & (owner_q == OwnLs);

    // A load is a single beat: its first beat ends the transfer even if the
    // slave forgets rlast.
    assign r_done  = r_beat & (m_rlast | (owner_q == OwnLs));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        len_err_d    = len_err_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arsize_d     = arsize_q;
        // Masks live for exactly one cycle after a completion.
        ic_mask_d    = 1'b0;
        ls_mask_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_ls) begin
                    state_d  = StAr;
                    owner_d  = OwnLs;
                    araddr_d = ls_addr;
                    arlen_d  = 8'd0;
                    arsize_d = ls_arsize;
                    // Only count grants that actually made the icache wait.
                    if (ic_cand && !starve_hit) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (grant_ic) begin
                    state_d      = StAr;
                    owner_d      = OwnIc;
                    araddr_d     = ic_paddr;
                    arlen_d      = ic_arlen;
                    arsize_d     = ic_arsize;
                    starve_cnt_d = '0;
                end
            end

            StAr: begin
                // AR payload is held in registers, so it stays stable here
                // regardless of what the requester does with its inputs.
                if (m_arready) begin
                    state_d    = StR;
                    beat_cnt_d = 8'd0;
                end
            end

            StR: begin
                if (r_beat) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    // beat_cnt_q is the count before this beat, so a correct
                    // burst has beat_cnt_q == arlen on its last beat.
                    if (m_rlast && (beat_cnt_q != arlen_q)) begin
                        len_err_d = 1'b1;
                    end
                end
                if (r_done) begin
                    state_d   = StIdle;
                    owner_d   = OwnNone;
                    ic_mask_d = (owner_q == OwnIc);
                    ls_mask_d = (owner_q == OwnLs);
                end
            end

            default: begin
                state_d = StIdle;
                owner_d = OwnNone;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            owner_q      <= OwnNone;
            starve_cnt_q <= '0;
            beat_cnt_q   <= 8'd0;
            len_err_q    <= 1'b0;
            ic_mask_q    <= 1'b0;
            ls_mask_q    <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= 8'd0;
            arsize_q     <= 3'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            len_err_q    <= len_err_d;
            ic_mask_q    <= ic_mask_d;
            ls_mask_q    <= ls_mask_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arsize_q     <= arsize_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign m_arvalid = (state_q == StAr);
    assign m_araddr  = araddr_q;
    assign m_arlen   = arlen_q;
    assign m_arsize  = arsize_q;

    // Beats arriving in StIdle (left over from before a reset) are accepted
    // and dropped; only StAr back-pressures the R channel.
    assign m_rready  = (state_q != StAr);

    // Return data is routed in the same cycle; non-owners see zeros.
    assign ic_rvalid = ic_beat;
    assign ic_rlast  = ic_beat & m_rlast;
    assign ic_rdata  = ic_beat ? m_rdata : '0;

    assign ls_rvalid = ls_beat;
    assign ls_rdata  = ls_beat ? m_rdata : '0;
    assign ls_rresp  = ls_beat ? m_rresp : 2'b00;

    assign len_err   = len_err_q;

endmodule

// File: tb/tb_ysyx_23060025_rd_arbiter.sv
// Directed self-checking bench for ysyx_23060025_rd_arbiter.
// Inputs change 2 time units after each rising edge; outputs are sampled one
// unit later, well away from the edge.

module tb_ysyx_23060025_rd_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        ic_psel = 1'b0;
    logic [31:0] ic_paddr = '0;
    logic [7:0]  ic_arlen = '0;
    logic [2:0]  ic_arsize = '0;
    logic        ic_rvalid;
    logic        ic_rlast;
    logic [31:0] ic_rdata;

    logic        ls_req = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [2:0]  ls_arsize = '0;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic [1:0]  ls_rresp;

    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic        m_rvalid = 1'b0;
    logic        m_rready;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0;
    logic        m_rlast = 1'b0;
    logic        len_err;

    int checks   = 0;
    int failures = 0;

    ysyx_23060025_rd_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .STARVE_MAX(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ic_psel   (ic_psel),
        .ic_paddr  (ic_paddr),
        .ic_arlen  (ic_arlen),
        .ic_arsize (ic_arsize),
        .ic_rvalid (ic_rvalid),
        .ic_rlast  (ic_rlast),
        .ic_rdata  (ic_rdata),
        .ls_req    (ls_req),
        .ls_addr   (ls_addr),
        .ls_arsize (ls_arsize),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .ls_rresp  (ls_rresp),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rlast   (m_rlast),
        .len_err   (len_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called in the AR cycle: checks the request, then completes the handshake.
    task automatic ar_cycle(input string tag, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size);
        #1;
        chk({tag, "_arvalid"}, {31'd0, m_arvalid}, 32'd1);
        chk({tag, "_araddr"}, m_araddr, addr);
        chk({tag, "_arlen"}, {24'd0, m_arlen}, {24'd0, len});
        chk({tag, "_arsize"}, {29'd0, m_arsize}, {29'd0, size});
        chk({tag, "_rready_ar"}, {31'd0, m_rready}, 32'd0);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
    endtask

    // Drives n icache beats; rlast on beat number last_at (1-based, 0 = never).
    task automatic ic_beats(input string tag, input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            m_rvalid = 1'b1;
            m_rdata  = 32'hC0DE_0000 + 32'(i);
            m_rlast  = (i == last_at - 1);
            #1;
            chk($sformatf("%s_ic_rvalid%0d", tag, i), {31'd0, ic_rvalid}, 32'd1);
            chk($sformatf("%s_ic_rlast%0d", tag, i), {31'd0, ic_rlast},
                (i == last_at - 1) ? 32'd1 : 32'd0);
            chk($sformatf("%s_ic_rdata%0d", tag, i), ic_rdata, 32'hC0DE_0000 + 32'(i));
            chk($sformatf("%s_ls_quiet%0d", tag, i), {31'd0, ls_rvalid}, 32'd0);
            tick();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rdata  = '0;
    endtask

    // Single load beat with rlast.
    task automatic ls_beat(input string tag, input logic [31:0] data, input logic [1:0] resp);
        m_rvalid = 1'b1;
        m_rdata  = data;
        m_rresp  = resp;
        m_rlast  = 1'b1;
        #1;
        chk({tag, "_ls_rvalid"}, {31'd0, ls_rvalid}, 32'd1);
        chk({tag, "_ls_rdata"}, ls_rdata, data);
        chk({tag, "_ls_rresp"}, {30'd0, ls_rresp}, {30'd0, resp});
        chk({tag, "_ic_quiet"}, {31'd0, ic_rvalid}, 32'd0);
        tick();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rresp  = 2'b00;
        m_rdata  = '0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        #1;
        chk("rst_arvalid", {31'd0, m_arvalid}, 32'd0);
        chk("rst_ic_rvalid", {31'd0, ic_rvalid}, 32'd0);
        chk("rst_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
        chk("rst_len_err", {31'd0, len_err}, 32'd0);
        chk("rst_rready", {31'd0, m_rready}, 32'd1);
        reset = 1'b0;

        // Stray beat in idle is sunk and dropped.
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        m_rdata  = 32'h55;
        #1;
        chk("idle_stray_ic", {31'd0, ic_rvalid}, 32'd0);
        chk("idle_stray_ls", {31'd0, ls_rvalid}, 32'd0);
        chk("idle_stray_rready", {31'd0, m_rready}, 32'd1);
        tick();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        #1;
        chk("idle_stray_len_err", {31'd0, len_err}, 32'd0);
        chk("idle_stray_arvalid", {31'd0, m_arvalid}, 32'd0);
        tick();

        // ---------------- t1: plain icache burst ----------------
        ic_psel   = 1'b1;
        ic_paddr  = 32'h8000_0010;
        ic_arlen  = 8'd3;
        ic_arsize = 3'd2;
        #1;
        chk("t1_req_cycle_arvalid", {31'd0, m_arvalid}, 32'd0);
        tick();
        ar_cycle("t1", 32'h8000_0010, 8'd3, 3'd2);
        ic_beats("t1", 4, 4);
        // ic_psel still high this cycle: must be masked, no second grant.
        #1;
        chk("t1_done_ic_rvalid", {31'd0, ic_rvalid}, 32'd0);
        tick();
        ic_psel = 1'b0;
        #1;
        chk("t1_no_dup_grant", {31'd0, m_arvalid}, 32'd0);
        chk("t1_len_err", {31'd0, len_err}, 32'd0);
        tick();

        // ---------------- t2: tie, LSU first ----------------
        ic_psel   = 1'b1;
        ic_paddr  = 32'h8000_0100;
        ic_arlen  = 8'd3;
        ls_req    = 1'b1;
        ls_addr   = 32'hA000_1234;
        ls_arsize = 3'd1;
        tick();
        ar_cycle("t2_ls", 32'hA000_1234, 8'd0, 3'd1);
        ls_beat("t2", 32'hDEAD_BEEF, 2'b00);
        // Idle cycle right after the load: LSU masked, icache takes the grant.
        #1;
        chk("t2_ls_pulse", {31'd0, ls_rvalid}, 32'd0);
        chk("t2_idle_arvalid", {31'd0, m_arvalid}, 32'd0);
        tick();
        ls_req = 1'b0;
        ar_cycle("t2_ic", 32'h8000_0100, 8'd3, 3'd2);
        ic_beats("t2", 4, 4);
        ic_psel = 1'b0;
        tick();

        // ---------------- t3: starvation guard ----------------
        ls_req    = 1'b1;
        ls_arsize = 3'd2;
        ic_paddr  = 32'h8000_0200;
        ic_arlen  = 8'd1;
        for (int g = 0; g < 4; g++) begin
            ls_addr = 32'hA000_0100 + 32'(g * 4);
            ic_psel = 1'b1;
            tick();
            ar_cycle($sformatf("t3_ls%0d", g), 32'hA000_0100 + 32'(g * 4), 8'd0, 3'd2);
            ls_beat($sformatf("t3_ls%0d", g), 32'h1111_0000 + 32'(g), 2'(g));
            // Masked cycle: icache steps back so the next tie is a real contest.
            ic_psel = 1'b0;
            #1;
            chk($sformatf("t3_masked%0d_arvalid", g), {31'd0, m_arvalid}, 32'd0);
            tick();
            #1;
            chk($sformatf("t3_no_regrant%0d", g), {31'd0, m_arvalid}, 32'd0);
        end
        ls_addr = 32'hA000_0200;
        ic_psel = 1'b1;
        tick();
        ls_req = 1'b0;
        ar_cycle("t3_ic_forced", 32'h8000_0200, 8'd1, 3'd2);
        ic_beats("t3", 2, 2);
        ic_psel = 1'b0;
        tick();

        // ---------------- t4: delayed arready ----------------
        ic_psel  = 1'b1;
        ic_paddr = 32'h8000_0400;
        ic_arlen = 8'd1;
        tick();
        // Requester inputs wander and the bus shows junk beats while waiting.
        ic_paddr = 32'hFFFF_FFFC;
        ic_arlen = 8'd7;
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        m_rdata  = 32'h0BAD;
        for (int w = 0; w < 5; w++) begin
            #1;
            chk($sformatf("t4_wait%0d_arvalid", w), {31'd0, m_arvalid}, 32'd1);
            chk($sformatf("t4_wait%0d_araddr", w), m_araddr, 32'h8000_0400);
            chk($sformatf("t4_wait%0d_arlen", w), {24'd0, m_arlen}, 32'd1);
            chk($sformatf("t4_wait%0d_ic_rvalid", w), {31'd0, ic_rvalid}, 32'd0);
            chk($sformatf("t4_wait%0d_rready", w), {31'd0, m_rready}, 32'd0);
            tick();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        ar_cycle("t4", 32'h8000_0400, 8'd1, 3'd2);
        ic_beats("t4", 2, 2);
        ic_psel = 1'b0;
        #1;
        chk("t4_len_err", {31'd0, len_err}, 32'd0);
        tick();

        // ---------------- t5: early rlast ----------------
        ic_psel  = 1'b1;
        ic_paddr = 32'h8000_0800;
        ic_arlen = 8'd3;
        tick();
        ar_cycle("t5", 32'h8000_0800, 8'd3, 3'd2);
        ic_beats("t5", 2, 2);
        ic_psel = 1'b0;
        #1;
        chk("t5_len_err_set", {31'd0, len_err}, 32'd1);
        chk("t5_idle_rready", {31'd0, m_rready}, 32'd1);
        chk("t5_idle_arvalid", {31'd0, m_arvalid}, 32'd0);
        tick();
        m_rvalid = 1'b1;
        #1;
        chk("t5_idle_no_route", {31'd0, ic_rvalid}, 32'd0);
        m_rvalid = 1'b0;
        tick();
        tick();
        #1;
        chk("t5_len_err_sticky", {31'd0, len_err}, 32'd1);
        tick();

        // ---------------- t6: reset mid-burst ----------------
        ic_psel  = 1'b1;
        ic_paddr = 32'h8000_0C00;
        ic_arlen = 8'd3;
        tick();
        ar_cycle("t6", 32'h8000_0C00, 8'd3, 3'd2);
        ic_beats("t6", 1, 0);
        m_rvalid = 1'b1;
        m_rdata  = 32'h22;
        reset    = 1'b1;
        #1;
        chk("t6_beat2_routed", {31'd0, ic_rvalid}, 32'd1);
        tick();
        reset    = 1'b0;
        ic_psel  = 1'b0;
        m_rdata  = 32'h33;
        #1;
        chk("t6_post_ic_rvalid", {31'd0, ic_rvalid}, 32'd0);
        chk("t6_post_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
        chk("t6_post_arvalid", {31'd0, m_arvalid}, 32'd0);
        chk("t6_post_len_err", {31'd0, len_err}, 32'd0);
        chk("t6_post_rready", {31'd0, m_rready}, 32'd1);
        tick();
        m_rlast = 1'b1;
        #1;
        chk("t6_beat4_ic_rvalid", {31'd0, ic_rvalid}, 32'd0);
        chk("t6_beat4_ic_rlast", {31'd0, ic_rlast}, 32'd0);
        tick();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        #1;
        chk("t6_end_len_err", {31'd0, len_err}, 32'd0);
        chk("t6_end_arvalid", {31'd0, m_arvalid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
